// File: rtl/alignment_output_buffer_if.sv
// Symbol-pair stream and status bundle between traceback, the alignment
// output buffer and its downstream consumer / controller.
interface alignment_output_buffer_if #(
   parameter int SYM_W = 3,
   parameter int LEN_W = 7
);
   logic             in_valid;
   logic [SYM_W-1:0] in_query_sym;
   logic [SYM_W-1:0] in_database_sym;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [SYM_W-1:0] out_query_sym;
   logic [SYM_W-1:0] out_database_sym;
   logic             out_last;
   logic [LEN_W-1:0] align_len;
   logic             overflow;
   logic             busy;
   logic             done;

   modport slave (
      input  in_valid, in_query_sym, in_database_sym, out_ready,
      output in_ready, out_valid, out_query_sym, out_database_sym, out_last,
             align_len, overflow, busy, done
   );

   modport master (
      output in_valid, in_query_sym, in_database_sym, out_ready,
      input  in_ready, out_valid, out_query_sym, out_database_sym, out_last,
             align_len, overflow, busy, done
   );
endinterface

// File: rtl/alignment_output_buffer.sv
// Collects one framed traceback alignment (emitted end-to-start) into a LIFO
// and replays it start-to-end on a valid/ready stream.
module alignment_output_buffer #(
   parameter int                  SEQ_LENGTH     = 32,
   parameter int                  LETTER_WIDTH   = 2,
   parameter int                  DEPTH          = 2 * SEQ_LENGTH,
   parameter int                  LEN_W          = $clog2(DEPTH + 1),
   parameter logic [LETTER_WIDTH:0] LINE_CODE      = 3'b100,
   parameter logic [LETTER_WIDTH:0] START_END_CODE = 3'b111
) (
   input  logic                       clk,
   input  logic                       rst,
   alignment_output_buffer_if.slave   bus
);
   localparam int SYM_W  = LETTER_WIDTH + 1;
   localparam int PAIR_W = 2 * SYM_W;
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
   localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

   // A gap symbol equal to the delimiter would make gap pairs look like frames.
   if (LINE_CODE == START_END_CODE) begin : g_bad_codes
      $error("alignment_output_buffer: LINE_CODE must differ from START_END_CODE");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_DRAIN
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [LEN_W-1:0]    r_ptr;
   logic [LEN_W-1:0]    r_align_len;
   logic                r_overflow;
   logic                r_done;
   logic [PAIR_W-1:0]   r_mem [DEPTH];

   logic                w_in_ready;
   logic                w_marker;
   logic                w_accept;
   logic                w_out_valid;
   logic                w_handshake;
   logic                w_wr_en;
   logic [LEN_W-1:0]    w_rd_ptr;
   logic [PAIR_W-1:0]   w_rd_pair;

   assign w_marker    = (bus.in_query_sym == START_END_CODE) &&
                        (bus.in_database_sym == START_END_CODE);
   assign w_accept    = bus.in_valid && w_in_ready;
   assign w_out_valid = (r_state == S_DRAIN) && (r_ptr != '0);
   assign w_handshake = w_out_valid && bus.out_ready;
   assign w_wr_en     = (r_state == S_COLLECT) && w_accept && !w_marker &&
                        (r_ptr != DEPTH_L);
   assign w_rd_ptr    = r_ptr - ONE_L;

   always_comb begin
      w_state_next = r_state;
      w_in_ready   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (w_accept && w_marker) w_state_next = S_COLLECT;
         end
         S_COLLECT: begin
            w_in_ready = 1'b1;
            if (w_accept && w_marker) w_state_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (r_ptr == '0)
               w_state_next = S_IDLE;
            else if (w_handshake && (r_ptr == ONE_L))
               w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_align_len <= '0;
         r_overflow  <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_done  <= (r_state == S_DRAIN) && (w_state_next == S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (w_accept && w_marker) begin
                  r_ptr      <= '0;
                  r_overflow <= 1'b0;
               end
            end
            S_COLLECT: begin
               if (w_accept) begin
                  if (w_marker)
                     r_align_len <= r_ptr;
                  else if (r_ptr == DEPTH_L)
                     r_overflow <= 1'b1;
                  else
                     r_ptr <= r_ptr + ONE_L;
               end
            end
            S_DRAIN: begin
               if (w_handshake) r_ptr <= r_ptr - ONE_L;
            end
            default: ;
         endcase
      end
   end

   // Storage is don't-care after reset, so it carries no reset.
   always_ff @(posedge clk) begin
      if (w_wr_en)
         r_mem[r_ptr[ADDR_W-1:0]] <= {bus.in_query_sym, bus.in_database_sym};
   end

   assign w_rd_pair = w_out_valid ? r_mem[w_rd_ptr[ADDR_W-1:0]] : '0;

   assign bus.in_ready         = w_in_ready;
   assign bus.out_valid        = w_out_valid;
   assign bus.out_query_sym    = w_rd_pair[PAIR_W-1:SYM_W];
   assign bus.out_database_sym = w_rd_pair[SYM_W-1:0];
   assign bus.out_last         = w_out_valid && (r_ptr == ONE_L);
   assign bus.align_len        = r_align_len;
   assign bus.overflow         = r_overflow;
   assign bus.busy             = (r_state != S_IDLE);
   assign bus.done             = r_done;
endmodule

// File: tb/tb_alignment_output_buffer.sv
// Self-checking bench for alignment_output_buffer: frames of random letter
// pairs are compared against a LIFO reference built from the input queue.
module tb_alignment_output_buffer;
   localparam int SEQ_LENGTH   = 32;
   localparam int LETTER_WIDTH = 2;
   localparam int SYM_W        = LETTER_WIDTH + 1;
   localparam int DEPTH        = 2 * SEQ_LENGTH;
   localparam int LEN_W        = $clog2(DEPTH + 1);
   localparam logic [2:0] GAP  = 3'b100;
   localparam logic [2:0] MRK  = 3'b111;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alignment_output_buffer_if #(.SYM_W(SYM_W), .LEN_W(LEN_W)) bus ();

   alignment_output_buffer #(
      .SEQ_LENGTH  (SEQ_LENGTH),
      .LETTER_WIDTH(LETTER_WIDTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   logic [5:0] in_q[$];
   logic [5:0] got_q[$];
   bit         last_q[$];
   int         stab_err, done_cyc, done_cnt, valid_cnt;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] q, input logic [2:0] d);
      bus.in_valid        = 1'b1;
      bus.in_query_sym    = q;
      bus.in_database_sym = d;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic send_marker();
      send(MRK, MRK);
   endtask

   // Start marker followed by n random letter pairs (no end marker).
   task automatic send_frame(input int n, input bit gaps);
      logic [2:0] q, d;
      in_q.delete();
      send_marker();
      for (int i = 0; i < n; i++) begin
         if (gaps && ($urandom_range(0, 3) == 0)) tick();
         q = 3'($urandom_range(0, 4));
         d = 3'($urandom_range(0, 4));
         in_q.push_back({q, d});
         send(q, d);
      end
   endtask

   // Observes the drain: records handshakes, last flags, stall stability and done.
   task automatic drain_monitor(input int mode, input int max_cyc);
      logic [5:0] prev;
      bit         prev_stall;
      int         pat[5] = '{1, 0, 0, 1, 1};
      prev_stall = 1'b0;
      prev       = '0;
      got_q.delete();
      last_q.delete();
      stab_err  = 0;
      done_cyc  = -1;
      done_cnt  = 0;
      valid_cnt = 0;
      for (int c = 0; c < max_cyc; c++) begin
         case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = (c < 5) ? pat[c][0] : 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (prev_stall && ({bus.out_query_sym, bus.out_database_sym} !== prev))
            stab_err++;
         if (bus.done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (bus.out_valid === 1'b1) valid_cnt++;
         if (bus.out_valid === 1'b1 && bus.out_ready) begin
            got_q.push_back({bus.out_query_sym, bus.out_database_sym});
            last_q.push_back(bus.out_last);
         end
         prev_stall = (bus.out_valid === 1'b1) && !bus.out_ready;
         prev       = {bus.out_query_sym, bus.out_database_sym};
         @(posedge clk);
         #1;
         if (done_cyc >= 0 && c >= done_cyc + 2) break;
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_query_sym = '0;
      bus.in_database_sym = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b exp 0", bus.out_last); end
      checks++; if (bus.align_len !== '0) begin errors++; $display("FAIL reset_align_len got %0d exp 0", bus.align_len); end
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", bus.overflow); end
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b exp 00", bus.busy, bus.done); end
      checks++; if ({bus.out_query_sym, bus.out_database_sym} !== 6'd0) begin errors++; $display("FAIL reset_out_sym got %h exp 0", {bus.out_query_sym, bus.out_database_sym}); end
      rst = 1'b0;
      tick();
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b exp 1", bus.in_ready); end
   endtask

   task automatic test_basic();
      logic [5:0] exp_q[3] = '{{3'd3, 3'd3}, {3'd2, GAP}, {3'd0, 3'd1}};
      send_marker();
      send(3'd0, 3'd1);
      send(3'd2, GAP);
      send(3'd3, 3'd3);
      send_marker();
      checks++; if (bus.out_valid !== 1'b1 || {bus.out_query_sym, bus.out_database_sym} !== exp_q[0]) begin
         errors++; $display("FAIL basic_latency got v=%b %h exp v=1 %h", bus.out_valid, {bus.out_query_sym, bus.out_database_sym}, exp_q[0]); end
      checks++; if (bus.align_len !== LEN_W'(3)) begin errors++; $display("FAIL basic_align_len got %0d exp 3", bus.align_len); end
      drain_monitor(0, 20);
      checks++; if (got_q.size() != 3) begin errors++; $display("FAIL basic_count got %0d exp 3", got_q.size()); end
      for (int k = 0; k < got_q.size() && k < 3; k++) begin
         checks++; if (got_q[k] !== exp_q[k] || last_q[k] !== (k == 2)) begin
            errors++; $display("FAIL basic_pair%0d got %h last %b exp %h last %b", k, got_q[k], last_q[k], exp_q[k], k == 2); end
      end
      checks++; if (done_cyc != 3 || done_cnt != 1) begin errors++; $display("FAIL basic_done got cyc %0d cnt %0d exp cyc 3 cnt 1", done_cyc, done_cnt); end
   endtask

   task automatic test_stall();
      logic [5:0] exp_q[3] = '{{3'd3, 3'd3}, {3'd2, GAP}, {3'd0, 3'd1}};
      send_marker();
      send(3'd0, 3'd1);
      send(3'd2, GAP);
      send(3'd3, 3'd3);
      send_marker();
      drain_monitor(1, 30);
      checks++; if (stab_err != 0) begin errors++; $display("FAIL stall_stable got %0d changes exp 0", stab_err); end
      checks++; if (got_q.size() != 3) begin errors++; $display("FAIL stall_count got %0d exp 3", got_q.size()); end
      for (int k = 0; k < got_q.size() && k < 3; k++) begin
         checks++; if (got_q[k] !== exp_q[k] || last_q[k] !== (k == 2)) begin
            errors++; $display("FAIL stall_pair%0d got %h last %b exp %h last %b", k, got_q[k], last_q[k], exp_q[k], k == 2); end
      end
      checks++; if (done_cyc != 5 || done_cnt != 1) begin errors++; $display("FAIL stall_done got cyc %0d cnt %0d exp cyc 5 cnt 1", done_cyc, done_cnt); end
   endtask

   task automatic test_empty();
      send_marker();
      send_marker();
      checks++; if (bus.align_len !== '0) begin errors++; $display("FAIL empty_align_len got %0d exp 0", bus.align_len); end
      drain_monitor(0, 10);
      checks++; if (valid_cnt != 0) begin errors++; $display("FAIL empty_out_valid got %0d valid cycles exp 0", valid_cnt); end
      checks++; if (done_cyc != 1 || done_cnt != 1) begin errors++; $display("FAIL empty_done got cyc %0d cnt %0d exp cyc 1 cnt 1", done_cyc, done_cnt); end
   endtask

   task automatic test_overflow();
      send_frame(DEPTH + 5, 1'b0);
      send_marker();
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", bus.overflow); end
      checks++; if (bus.align_len !== LEN_W'(DEPTH)) begin errors++; $display("FAIL ovf_align_len got %0d exp %0d", bus.align_len, DEPTH); end
      drain_monitor(0, DEPTH + 20);
      checks++; if (got_q.size() != DEPTH) begin errors++; $display("FAIL ovf_count got %0d exp %0d", got_q.size(), DEPTH); end
      for (int k = 0; k < got_q.size() && k < DEPTH; k++) begin
         checks++; if (got_q[k] !== in_q[DEPTH-1-k] || last_q[k] !== (k == DEPTH - 1)) begin
            errors++; $display("FAIL ovf_pair%0d got %h exp %h", k, got_q[k], in_q[DEPTH-1-k]); end
      end
      checks++; if (done_cyc != DEPTH || done_cnt != 1) begin errors++; $display("FAIL ovf_done got cyc %0d cnt %0d exp cyc %0d cnt 1", done_cyc, done_cnt, DEPTH); end
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", bus.overflow); end
      send_marker();
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", bus.overflow); end
      send_marker();
      drain_monitor(0, 10);
   endtask

   task automatic test_drain_ignore();
      send_frame(10, 1'b0);
      send_marker();
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL ign_in_ready got %b exp 0", bus.in_ready); end
      bus.in_valid        = 1'b1;
      bus.in_query_sym    = 3'($urandom_range(0, 4));
      bus.in_database_sym = 3'($urandom_range(0, 4));
      drain_monitor(2, 200);
      bus.in_valid = 1'b0;
      checks++; if (bus.align_len !== LEN_W'(10)) begin errors++; $display("FAIL ign_align_len got %0d exp 10", bus.align_len); end
      checks++; if (got_q.size() != 10) begin errors++; $display("FAIL ign_count got %0d exp 10", got_q.size()); end
      for (int k = 0; k < got_q.size() && k < 10; k++) begin
         checks++; if (got_q[k] !== in_q[9-k]) begin errors++; $display("FAIL ign_pair%0d got %h exp %h", k, got_q[k], in_q[9-k]); end
      end
      checks++; if (stab_err != 0 || done_cnt != 1) begin errors++; $display("FAIL ign_stab_done got %0d/%0d exp 0/1", stab_err, done_cnt); end
   endtask

   task automatic test_reset_mid_drain();
      int spurious;
      send_frame(7, 1'b0);
      send_marker();
      bus.out_ready = 1'b1;
      tick(); tick(); tick();
      bus.out_ready = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b1 || {bus.out_query_sym, bus.out_database_sym} !== in_q[3]) begin
         errors++; $display("FAIL rmd_remaining got v=%b %h exp v=1 %h", bus.out_valid, {bus.out_query_sym, bus.out_database_sym}, in_q[3]); end
      rst = 1'b1;
      #1;
      checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rmd_in_reset got v=%b busy=%b exp 0 0", bus.out_valid, bus.busy); end
      tick();
      rst = 1'b0;
      spurious = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus.done !== 1'b0) spurious++;
         tick();
      end
      checks++; if (spurious != 0) begin errors++; $display("FAIL rmd_no_done got %0d pulses exp 0", spurious); end
      send_frame(2, 1'b0);
      send_marker();
      drain_monitor(0, 20);
      checks++; if (got_q.size() != 2) begin errors++; $display("FAIL rmd_next_count got %0d exp 2", got_q.size()); end
      for (int k = 0; k < got_q.size() && k < 2; k++) begin
         checks++; if (got_q[k] !== in_q[1-k] || last_q[k] !== (k == 1)) begin
            errors++; $display("FAIL rmd_next_pair%0d got %h exp %h", k, got_q[k], in_q[1-k]); end
      end
      checks++; if (done_cyc != 2 || done_cnt != 1) begin errors++; $display("FAIL rmd_next_done got cyc %0d cnt %0d exp 2 1", done_cyc, done_cnt); end
   endtask

   task automatic test_random();
      int n, n_exp, mode;
      for (int f = 0; f < 6; f++) begin
         n     = $urandom_range(0, DEPTH + 6);
         n_exp = (n > DEPTH) ? DEPTH : n;
         mode  = ($urandom_range(0, 1) == 0) ? 0 : 2;
         send_frame(n, 1'b1);
         send_marker();
         checks++; if (bus.align_len !== LEN_W'(n_exp) || bus.overflow !== (n > DEPTH)) begin
            errors++; $display("FAIL rnd%0d_status got len %0d ovf %b exp len %0d ovf %b", f, bus.align_len, bus.overflow, n_exp, n > DEPTH); end
         drain_monitor(mode, 4 * DEPTH + 40);
         checks++; if (got_q.size() != n_exp) begin errors++; $display("FAIL rnd%0d_count got %0d exp %0d", f, got_q.size(), n_exp); end
         for (int k = 0; k < got_q.size() && k < n_exp; k++) begin
            checks++; if (got_q[k] !== in_q[n_exp-1-k] || last_q[k] !== (k == n_exp - 1)) begin
               errors++; $display("FAIL rnd%0d_pair%0d got %h exp %h", f, k, got_q[k], in_q[n_exp-1-k]); end
         end
         checks++; if (stab_err != 0 || done_cnt != 1 || (mode == 0 && done_cyc != ((n_exp == 0) ? 1 : n_exp))) begin
            errors++; $display("FAIL rnd%0d_done got stab %0d cnt %0d cyc %0d exp 0 1 %0d", f, stab_err, done_cnt, done_cyc, (n_exp == 0) ? 1 : n_exp); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_empty();
      test_overflow();
      test_drain_ignore();
      test_reset_mid_drain();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end
endmodule
